// File: rtl/mt_pkg.sv
// Shared parameters, types and window helper for the multithreaded fetch stage.
package mt_pkg;
    localparam int NUM_THREADS      = 5;
    localparam int SLOTS_PER_THREAD = 100;
    localparam int ADDR_W           = 9;
    localparam int TID_W            = 3;

    typedef logic [TID_W-1:0]  tid_t;
    typedef logic [ADDR_W-1:0] iaddr_t;

    function automatic iaddr_t thread_base(input tid_t tid);
        return iaddr_t'(int'(tid) * SLOTS_PER_THREAD);
    endfunction
endpackage

// File: rtl/rr_thread_picker.sv
// Round-robin thread picker: first active thread at or after rr_ptr, modulo NUM_THREADS.
module rr_thread_picker
    import mt_pkg::*;
(
    input  logic [NUM_THREADS-1:0] active,
    input  tid_t                   rr_ptr,
    output tid_t                   sel,
    output logic                   any_active
);
    int idx;

    // Scan from the far end so the closest active thread to rr_ptr wins last.
    always_comb begin
        sel        = rr_ptr;
        any_active = 1'b0;
        idx        = 0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_THREADS;
            if (active[idx]) begin
                sel        = tid_t'(idx);
                any_active = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mt_fetch_scheduler.sv
// Fetch stage: per-thread PCs, round-robin issue into imem, IF/ID register, redirects and halts.
module mt_fetch_scheduler
    import mt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [TID_W-1:0]  redirect_tid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_valid,
    input  logic [TID_W-1:0]  halt_tid,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rd,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [TID_W-1:0]  if_tid,
    output logic [ADDR_W-1:0] if_pc,
    output logic              all_halted,
    output logic              redirect_err
);
    iaddr_t                 pc_q [NUM_THREADS];
    iaddr_t                 pc_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] active_q, active_d;
    tid_t                   rr_ptr_q, rr_ptr_d;
    logic                   if_valid_q, if_valid_d;
    logic [31:0]            if_instr_q, if_instr_d;
    tid_t                   if_tid_q, if_tid_d;
    iaddr_t                 if_pc_q, if_pc_d;
    logic                   redirect_err_q, redirect_err_d;

    tid_t   sel;
    logic   any_active;
    iaddr_t sel_pc;
    iaddr_t redir_base;
    logic   redir_ok;
    logic   issue;

    rr_thread_picker u_picker (
        .active     (active_q),
        .rr_ptr     (rr_ptr_q),
        .sel        (sel),
        .any_active (any_active)
    );

    always_comb begin
        sel_pc = pc_q[0];
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (sel == tid_t'(t)) sel_pc = pc_q[t];
        end
    end

    // Out-of-range thread ids alias to a bogus base, so the id check must gate the window test.
    assign redir_base = thread_base(redirect_tid);
    assign redir_ok   = redirect_valid && (redirect_tid < tid_t'(NUM_THREADS)) &&
                        (redirect_pc >= redir_base) &&
                        (redirect_pc <= redir_base + iaddr_t'(SLOTS_PER_THREAD - 1));
    assign issue      = !stall && any_active;

    always_comb begin
        pc_d           = pc_q;
        active_d       = active_q;
        rr_ptr_d       = rr_ptr_q;
        if_valid_d     = if_valid_q;
        if_instr_d     = if_instr_q;
        if_tid_d       = if_tid_q;
        if_pc_d        = if_pc_q;
        redirect_err_d = redirect_err_q;

        if (issue) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rd;
            if_tid_d   = sel;
            if_pc_d    = sel_pc;
            rr_ptr_d   = (sel == tid_t'(NUM_THREADS - 1)) ? '0 : sel + 1'b1;
        end else if (!stall) begin
            if_valid_d = 1'b0;
        end

        for (int t = 0; t < NUM_THREADS; t++) begin
            if (issue && sel == tid_t'(t)) begin
                if (pc_q[t] == thread_base(tid_t'(t)) + iaddr_t'(SLOTS_PER_THREAD - 1))
                    pc_d[t] = thread_base(tid_t'(t));
                else
                    pc_d[t] = pc_q[t] + 1'b1;
            end
            if (redir_ok && redirect_tid == tid_t'(t)) pc_d[t] = redirect_pc;
            if (halt_valid && halt_tid == tid_t'(t)) active_d[t] = 1'b0;
        end

        if (issue && redir_ok && redirect_tid == sel) if_valid_d = 1'b0;
        if (redirect_valid && !redir_ok) redirect_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= thread_base(tid_t'(t));
            active_q       <= '1;
            rr_ptr_q       <= '0;
            if_valid_q     <= 1'b0;
            if_instr_q     <= '0;
            if_tid_q       <= '0;
            if_pc_q        <= '0;
            redirect_err_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            active_q       <= active_d;
            rr_ptr_q       <= rr_ptr_d;
            if_valid_q     <= if_valid_d;
            if_instr_q     <= if_instr_d;
            if_tid_q       <= if_tid_d;
            if_pc_q        <= if_pc_d;
            redirect_err_q <= redirect_err_d;
        end
    end

    assign imem_addr    = sel_pc;
    assign if_valid     = if_valid_q;
    assign if_instr     = if_instr_q;
    assign if_tid       = if_tid_q;
    assign if_pc        = if_pc_q;
    assign all_halted   = ~|active_q;
    assign redirect_err = redirect_err_q;
endmodule

// File: tb/tb_mt_fetch_scheduler.sv
// Directed plus randomized bench for mt_fetch_scheduler against a thread-table reference model.
module tb_mt_fetch_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [2:0]  redirect_tid = '0;
    logic [8:0]  redirect_pc = '0;
    logic        halt_valid = 1'b0;
    logic [2:0]  halt_tid = '0;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [2:0]  if_tid;
    logic [8:0]  if_pc;
    logic        all_halted;
    logic        redirect_err;

    int checks = 0;
    int errors = 0;

    int          m_pc [5];
    bit          m_act [5];
    int          m_rr;
    bit          m_vld;
    logic [31:0] m_instr;
    int          m_tid;
    int          m_ipc;
    bit          m_err;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [8:0] a);
        return {a, 23'h0} ^ (32'(a) * 32'h9E3779B1);
    endfunction

    assign imem_rd = mem_f(imem_addr);

    mt_fetch_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .halt_valid     (halt_valid),
        .halt_tid       (halt_tid),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_tid         (if_tid),
        .if_pc          (if_pc),
        .all_halted     (all_halted),
        .redirect_err   (redirect_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 5; t++) begin
            m_pc[t]  = t * 100;
            m_act[t] = 1'b1;
        end
        m_rr = 0; m_vld = 0; m_instr = 0; m_tid = 0; m_ipc = 0; m_err = 0;
    endtask

    function automatic int model_sel();
        for (int i = 0; i < 5; i++)
            if (m_act[(m_rr + i) % 5]) return (m_rr + i) % 5;
        return -1;
    endfunction

    task automatic cycle(input bit st, input bit rv, input int rt, input int rp,
                         input bit hv, input int ht, input bit rs);
        int  s;
        bit  iss;
        @(negedge clk);
        reset = rs; stall = st;
        redirect_valid = rv; redirect_tid = 3'(rt); redirect_pc = 9'(rp);
        halt_valid = hv; halt_tid = 3'(ht);
        #1;
        s = model_sel();
        if (!rs) begin
            chk("imem_addr", 32'(imem_addr), 32'((s >= 0) ? m_pc[s] : m_pc[m_rr]));
            chk("all_halted", 32'(all_halted), 32'(s < 0));
        end
        if (rs) begin
            model_reset();
        end else begin
            iss = !st && (s >= 0);
            if (iss) begin
                m_vld = 1; m_instr = mem_f(9'(m_pc[s])); m_tid = s; m_ipc = m_pc[s];
                m_pc[s] = (m_pc[s] == s * 100 + 99) ? s * 100 : m_pc[s] + 1;
                m_rr = (s + 1) % 5;
            end else if (!st) begin
                m_vld = 0;
            end
            if (rv) begin
                if (rt < 5 && rp >= rt * 100 && rp <= rt * 100 + 99) begin
                    m_pc[rt] = rp;
                    if (iss && rt == s) m_vld = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (hv && ht < 5) m_act[ht] = 0;
        end
        @(posedge clk);
        #1;
        chk("if_valid", 32'(if_valid), 32'(m_vld));
        if (m_vld || rs) begin
            chk("if_instr", if_instr, m_instr);
            chk("if_tid", 32'(if_tid), 32'(m_tid));
            chk("if_pc", 32'(if_pc), 32'(m_ipc));
        end
        chk("redirect_err", 32'(redirect_err), 32'(m_err));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_halted", 32'(all_halted), 32'd0);

        // Free run: addresses 0,100,200,300,400,1,...
        run(10);
        // Complete 500 issues: every window wraps back to its base.
        run(490);
        chk("wrap_addr", 32'(imem_addr), 32'd0);

        // Thread 0 issues, then redirect thread 1 while it is selected.
        run(1);
        cycle(0, 1, 1, 150, 0, 0, 0);
        chk("squash", 32'(if_valid), 32'd0);
        run(6);

        // Out-of-window redirect, then an out-of-range thread id.
        cycle(0, 1, 2, 50, 0, 0, 0);
        chk("err_set", 32'(redirect_err), 32'd1);
        cycle(0, 1, 6, 10, 0, 0, 0);
        run(3);

        // Three stall cycles with a redirect of thread 0 in the middle.
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 42, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        run(8);

        // Random phase without halts.
        for (int i = 0; i < 300; i++) begin
            int rt;
            rt = int'($urandom_range(0, 5));
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rt,
                  rt * 100 + int'($urandom_range(0, 109)), 0, 0, 0);
        end
        chk("err_sticky", 32'(redirect_err), 32'd1);

        // Halt 2 and 3 -> sequence 0,1,4.
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("err_cleared", 32'(redirect_err), 32'd0);
        cycle(0, 0, 0, 0, 1, 2, 0);
        cycle(0, 0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 1, 7, 0);
        run(9);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 1, 4, 0);
        run(3);
        chk("all_halted", 32'(all_halted), 32'd1);
        chk("halt_valid", 32'(if_valid), 32'd0);

        // Random phase with halts, stalls and redirects.
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 250; i++) begin
            int rt;
            rt = int'($urandom_range(0, 5));
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rt,
                  rt * 100 + int'($urandom_range(0, 109)),
                  $urandom_range(0, 49) == 0, int'($urandom_range(0, 6)), 0);
        end

        // Reset asserted in the middle of a stall with a pending redirect.
        cycle(0, 0, 0, 0, 0, 0, 1);
        run(4);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 77, 1, 1, 1);
        chk("midrst_addr", 32'(imem_addr), 32'd0);
        chk("midrst_valid", 32'(if_valid), 32'd0);
        run(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
